// File: rtl/btb_if.sv
// Lookup and update bus of the set-associative branch target buffer.
// The master side is the pipeline; the slave side is the BTB.
interface btb_if #(
  parameter int unsigned PC_W = 32
);
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] target_pc;
  logic            valid;
  logic            predictedTaken;
  logic            update;
  logic [PC_W-1:0] update_pc;
  logic [PC_W-1:0] update_target;
  logic            update_taken;
  logic            flush_all;
  logic [31:0]     hit_count;

  modport master (
    output pc, update, update_pc, update_target, update_taken, flush_all,
    input  target_pc, valid, predictedTaken, hit_count
  );

  modport slave (
    input  pc, update, update_pc, update_target, update_taken, flush_all,
    output target_pc, valid, predictedTaken, hit_count
  );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with saturating direction counters,
// true-LRU replacement, global flush and an update-hit counter.
module btb_assoc #(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned WAYS     = 2,
  parameter int unsigned CNT_BITS = 2,
  parameter int unsigned PC_W     = 32
) (
  input logic  clk,
  input logic  rst,
  btb_if.slave bus
);
  localparam int unsigned SETS   = ENTRIES / WAYS;
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned IDX_WS = (IDX_W == 0) ? 1 : IDX_W;
  localparam int unsigned TAG_W  = PC_W - 2 - IDX_W;
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [CNT_BITS-1:0] CNT_MAX    = '1;
  localparam logic [CNT_BITS-1:0] CNT_INIT   = CNT_BITS'(1 << (CNT_BITS - 1));
  localparam logic [WAY_W-1:0]    AGE_OLDEST = WAY_W'(WAYS - 1);

  logic                valid_q [SETS][WAYS];
  logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
  logic [PC_W-1:0]     tgt_q   [SETS][WAYS];
  logic [CNT_BITS-1:0] cnt_q   [SETS][WAYS];
  logic [WAY_W-1:0]    age_q   [SETS][WAYS];
  logic [31:0]         hit_count_q;

  logic [IDX_WS-1:0]   lk_idx, u_idx;
  logic [TAG_W-1:0]    lk_tag, u_tag;
  logic                lk_hit, lk_taken;
  logic [PC_W-1:0]     lk_tgt;
  logic                u_hit, inv_found, do_write;
  logic [WAY_W-1:0]    u_hit_way, inv_way, old_way, acc_way;
  logic [CNT_BITS-1:0] cur_cnt, cnt_nxt;
  logic                unused_lsb;

  // Fully associative configurations have no index bits at all.
  if (IDX_W > 0) begin : g_idx
    assign lk_idx = bus.pc[2 +: IDX_W];
    assign u_idx  = bus.update_pc[2 +: IDX_W];
  end else begin : g_no_idx
    assign lk_idx = '0;
    assign u_idx  = '0;
  end

  assign lk_tag     = bus.pc[PC_W-1 -: TAG_W];
  assign u_tag      = bus.update_pc[PC_W-1 -: TAG_W];
  assign unused_lsb = ^{bus.pc[1:0], bus.update_pc[1:0]};

  // Zero-latency lookup; never touches state.
  always_comb begin
    lk_hit   = 1'b0;
    lk_tgt   = '0;
    lk_taken = 1'b0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
        lk_hit   = 1'b1;
        lk_tgt   = tgt_q[lk_idx][w];
        lk_taken = cnt_q[lk_idx][w][CNT_BITS-1];
      end
    end
  end

  assign bus.valid          = lk_hit;
  assign bus.target_pc      = lk_tgt;
  assign bus.predictedTaken = lk_taken;
  assign bus.hit_count      = hit_count_q;

  // Update side: hit detection, victim choice and next counter value.
  always_comb begin
    u_hit     = 1'b0;
    u_hit_way = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    old_way   = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) begin
        u_hit     = 1'b1;
        u_hit_way = WAY_W'(w);
      end
      if (age_q[u_idx][w] == AGE_OLDEST) old_way = WAY_W'(w);
    end
    // Descending scan leaves the lowest-index invalid way selected.
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[u_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    acc_way = u_hit ? u_hit_way : (inv_found ? inv_way : old_way);
    cur_cnt = cnt_q[u_idx][acc_way];
    if (bus.update_taken) cnt_nxt = (cur_cnt == CNT_MAX) ? cur_cnt : cur_cnt + CNT_BITS'(1);
    else                  cnt_nxt = (cur_cnt == '0)      ? cur_cnt : cur_cnt - CNT_BITS'(1);
    do_write = bus.update && !bus.flush_all && (u_hit || bus.update_taken);
  end

  // Entry and LRU state; flush outranks a same-edge update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < int'(SETS); s++) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          valid_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          tgt_q[s][w]   <= '0;
          cnt_q[s][w]   <= '0;
          age_q[s][w]   <= WAY_W'(w);
        end
      end
    end else if (bus.flush_all) begin
      for (int s = 0; s < int'(SETS); s++) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          valid_q[s][w] <= 1'b0;
        end
      end
    end else if (do_write) begin
      valid_q[u_idx][acc_way] <= 1'b1;
      tag_q[u_idx][acc_way]   <= u_tag;
      tgt_q[u_idx][acc_way]   <= bus.update_target;
      cnt_q[u_idx][acc_way]   <= u_hit ? cnt_nxt : CNT_INIT;
      for (int w = 0; w < int'(WAYS); w++) begin
        if (WAY_W'(w) == acc_way)
          age_q[u_idx][w] <= '0;
        else if (age_q[u_idx][w] < age_q[u_idx][acc_way])
          age_q[u_idx][w] <= age_q[u_idx][w] + WAY_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hit_count_q <= '0;
    else if (bus.update && !bus.flush_all && u_hit)
      hit_count_q <= hit_count_q + 32'd1;
  end
endmodule
